switch_debounce_2ch: RTL and testbench

Two-channel switch conditioner placed directly upstream of the two-input gate stage. It takes raw, asynchronous, bouncing slide-switch or push-button levels `sw_a` and `sw_b`. It produces clean, synchronous, debounced levels `a` and `b` that drive the gate's inputs. It also produces single-cycle edge pulses so that downstream logic or LEDs can count or flag input changes.

---
 rtl/switch_debounce_2ch.sv | 166 ++++++++++++++++
 tb/tb_switch_debounce_2ch.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/switch_debounce_2ch.sv
// -----------------------------------------------------------------------------
// switch_debounce_2ch
//
// Purpose:
//   Two-channel switch conditioner. Each raw, bouncing switch level passes
//   through a two-flop synchronizer and then a four-state debounce FSM. A new
//   level reaches the output only after it has held for DB_CYCLES consecutive
//   synchronized cycles. The block also emits single-cycle edge pulses and a
//   combined change flag. Both channels are identical and share no state.
//
// Parameters:
//   DB_CYCLES : synchronized cycles a new level must hold (1 .. 2**CNT_W)
//   CNT_W     : width of each channel's stability counter
//
// Ports:
//   clk     in  : clock, all state updates on the rising edge
//   rst     in  : asynchronous active-high reset
//   sw_a    in  : raw switch level, channel A (asynchronous, bouncing)
//   sw_b    in  : raw switch level, channel B (asynchronous, bouncing)
//   a       out : debounced level, channel A (registered)
//   b       out : debounced level, channel B (registered)
//   a_rise  out : one-cycle pulse when a goes 0->1
//   a_fall  out : one-cycle pulse when a goes 1->0
//   b_rise  out : one-cycle pulse when b goes 0->1
//   b_fall  out : one-cycle pulse when b goes 1->0
//   chg     out : OR of the four edge pulses, registered alongside them
// -----------------------------------------------------------------------------
module switch_debounce_2ch #(
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_a,
  input  logic sw_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic chg
);

  typedef enum logic [1:0] {
    ST0   = 2'd0,  // accepted level 0
    WAIT1 = 2'd1,  // qualifying a 0->1 change
    ST1   = 2'd2,  // accepted level 1
    WAIT0 = 2'd3   // qualifying a 1->0 change
  } state_t;

  // Counter value on the cycle before acceptance. With DB_CYCLES = 2**CNT_W
  // this is all ones, so the counter still never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0] sw_raw;
  logic [1:0] lvl;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] acc_rise;
  logic [1:0] acc_fall;
  logic       chg_q;

  assign sw_raw = {sw_b, sw_a};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic                sync1_q;
      logic                sync2_q;
      state_t              state_q;
      logic [CNT_W-1:0]    cnt_q;
      logic                lvl_q;
      logic                rise_q;
      logic                fall_q;

      // Acceptance conditions, shared by the FSM and the combined chg flop so
      // that chg lands on exactly the same edge as the individual pulses.
      assign acc_rise[gi] = (state_q == WAIT1) && sync2_q  && (cnt_q == CNT_LAST);
      assign acc_fall[gi] = (state_q == WAIT0) && !sync2_q && (cnt_q == CNT_LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          state_q <= ST0;
          cnt_q   <= '0;
          lvl_q   <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
        end else begin
          sync1_q <= sw_raw[gi];
          sync2_q <= sync1_q;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
          case (state_q)
            ST0: begin
              cnt_q <= '0;
              if (sync2_q) begin
                state_q <= WAIT1;
              end
            end
            WAIT1: begin
              if (!sync2_q) begin
                // Bounce: back to the accepted level, qualification restarts.
                state_q <= ST0;
                cnt_q   <= '0;
              end else if (cnt_q == CNT_LAST) begin
                state_q <= ST1;
                cnt_q   <= '0;
                lvl_q   <= 1'b1;
                rise_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
            ST1: begin
              cnt_q <= '0;
              if (!sync2_q) begin
                state_q <= WAIT0;
              end
            end
            WAIT0: begin
              if (sync2_q) begin
                state_q <= ST1;
                cnt_q   <= '0;
              end else if (cnt_q == CNT_LAST) begin
                state_q <= ST0;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
                fall_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
            default: begin
              state_q <= ST0;
              cnt_q   <= '0;
            end
          endcase
        end
      end

      assign lvl[gi]  = lvl_q;
      assign rise[gi] = rise_q;
      assign fall[gi] = fall_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= |{acc_rise, acc_fall};
    end
  end

  assign a      = lvl[0];
  assign b      = lvl[1];
  assign a_rise = rise[0];
  assign a_fall = fall[0];
  assign b_rise = rise[1];
  assign b_fall = fall[1];
  assign chg    = chg_q;

endmodule

// File: tb/tb_switch_debounce_2ch.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce_2ch
//
// Directed bench for switch_debounce_2ch with default parameters. Outputs are
// packed as {a, b, a_rise, a_fall, b_rise, b_fall, chg} and compared against
// hand-computed vectors 1 ns after each rising edge. A switch change driven
// just after edge e is first sampled by sync1 at edge e+1 and accepted at
// edge e+1+2+DB_CYCLES, i.e. the 11th edge after the change is driven.
// -----------------------------------------------------------------------------
module tb_switch_debounce_2ch;

  localparam int DB = 8;

  logic clk;
  logic rst;
  logic sw_a;
  logic sw_b;
  logic a;
  logic b;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;
  logic chg;

  int total;
  int bad;

  switch_debounce_2ch #(
    .DB_CYCLES (DB),
    .CNT_W     (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_a   (sw_a),
    .sw_b   (sw_b),
    .a      (a),
    .b      (b),
    .a_rise (a_rise),
    .a_fall (a_fall),
    .b_rise (b_rise),
    .b_fall (b_fall),
    .chg    (chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {a, b, a_rise, a_fall, b_rise, b_fall, chg};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b (a b ar af br bf chg)", tag, got, exp);
    end else begin
      $display("ok   %s: %b", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps n cycles, expecting the same output vector after every edge.
  task automatic hold(input string tag, input int n, input logic [6:0] exp);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, outs(), exp);
    end
  endtask

  // After a change has just been driven: 10 quiet edges, acceptance on the
  // 11th edge, pulses gone on the 12th.
  task automatic accept(input string tag, input logic [6:0] pre,
                        input logic [6:0] at, input logic [6:0] post);
    for (int i = 0; i < DB + 2; i++) begin
      step();
      check({tag, "_pre"}, outs(), pre);
    end
    step();
    check({tag, "_edge"}, outs(), at);
    step();
    check({tag, "_post"}, outs(), post);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    sw_a  = 1'b1;
    sw_b  = 1'b1;

    // 1. Switches held high through reset, then release.
    hold("rst_hold", 3, 7'b0000000);
    rst = 1'b0;
    accept("rst_rel", 7'b0000000, 7'b1110101, 7'b1100000);

    // 2. Clean release then press on channel A; B stays put.
    sw_a = 1'b0;
    accept("a_fall", 7'b1100000, 7'b0101001, 7'b0100000);
    sw_a = 1'b1;
    accept("a_rise", 7'b0100000, 7'b1110001, 7'b1100000);

    // 4. Two-cycle low glitch while A is stably 1.
    sw_a = 1'b0;
    hold("glitch", 2, 7'b1100000);
    sw_a = 1'b1;
    hold("glitch", 15, 7'b1100000);

    // Bring A back to 0 before the bounce test.
    sw_a = 1'b0;
    accept("a_fall2", 7'b1100000, 7'b0101001, 7'b0100000);

    // 3. Bounce 1,0,1,0 at 3-cycle intervals, then hold 1.
    for (int seg = 0; seg < 4; seg++) begin
      sw_a = (seg % 2 == 0) ? 1'b1 : 1'b0;
      hold("bounce", 3, 7'b0100000);
    end
    sw_a = 1'b1;
    accept("bounce_fin", 7'b0100000, 7'b1110001, 7'b1100000);

    // 5. Both channels fall together, then rise together.
    sw_a = 1'b0;
    sw_b = 1'b0;
    accept("both_fall", 7'b1100000, 7'b0001011, 7'b0000000);
    sw_a = 1'b1;
    sw_b = 1'b1;
    accept("both_rise", 7'b0000000, 7'b1110101, 7'b1100000);

    // 6. Reset in the middle of WAIT1 on A (cnt = 5), B sitting at 1.
    sw_a = 1'b0;
    accept("a_fall3", 7'b1100000, 7'b0101001, 7'b0100000);
    sw_a = 1'b1;
    hold("wait1", 8, 7'b0100000);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", outs(), 7'b0000000);
    step();
    check("rst_mid", outs(), 7'b0000000);
    rst = 1'b0;
    accept("rst_mid_rel", 7'b0000000, 7'b1110101, 7'b1100000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
